// File: rtl/exp_tmr0_portb.sv
// Expansion-bus responder for the core's exp_* bus.
// Provides TMR0 (8-bit timer/counter with prescaler, external clock input and
// write-inhibit window) and PORTB (output latch plus TRIS direction register).
// Read data is registered and returned one clk after the read address.
module exp_tmr0_portb #(
  parameter logic [4:0] TMR0_ADDR   = 5'h01,
  parameter logic [4:0] PORTB_ADDR  = 5'h06,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exp_wr_en_i,
  input  logic [6:0] exp_wr_addr_i,
  input  logic [7:0] exp_dout_i,
  input  logic [6:0] exp_rd_addr_i,
  output logic [7:0] exp_din_o,
  input  logic       opt_wr_i,
  input  logic       tris_wr_i,
  input  logic [7:0] cfg_din_i,
  input  logic       t0cki_i,
  input  logic [7:0] portb_in_i,
  output logic [7:0] portb_out_o,
  output logic [7:0] portb_oe_o,
  output logic       t0_ovf_o
);

  // Ticks dropped after a TMR0 write, so a freshly written value holds for two clks.
  localparam logic [1:0] INHIBIT_CLKS = 2'd2;

  // Input synchronisers; the last stage is the one used by the logic.
  logic [SYNC_STAGES-1:0]      t0cki_sync_q;
  logic [SYNC_STAGES-1:0][7:0] portb_sync_q;
  logic                        t0cki_prev_q;

  // Architectural state.
  logic [7:0] tmr0_q,      tmr0_d;
  logic [7:0] presc_q,     presc_d;
  logic [1:0] inhibit_q,   inhibit_d;
  logic [5:0] opt_q,       opt_d;
  logic [7:0] trisb_q,     trisb_d;
  logic [7:0] portb_out_q, portb_out_d;
  logic [7:0] exp_din_q,   exp_din_d;
  logic       t0_ovf_q,    t0_ovf_d;

  // Decoded helpers.
  logic       t0cki_s;
  logic [7:0] portb_s;
  logic       t0_event;
  logic [7:0] presc_inc;
  logic       presc_tick;
  logic       tick;
  logic       inhibit_active;
  logic       wr_tmr0;
  logic       wr_portb;
  logic [4:0] rd_sel;
  logic [7:0] portb_rd;

  assign t0cki_s = t0cki_sync_q[SYNC_STAGES-1];
  assign portb_s = portb_sync_q[SYNC_STAGES-1];

  // Bank bits [6:5] are ignored so both registers mirror across all banks.
  assign wr_tmr0  = exp_wr_en_i && (exp_wr_addr_i[4:0] == TMR0_ADDR);
  assign wr_portb = exp_wr_en_i && (exp_wr_addr_i[4:0] == PORTB_ADDR);
  assign rd_sel   = exp_rd_addr_i[4:0];

  // Input pins read back the synchronised pin; output pins read back the latch.
  assign portb_rd = (trisb_q & portb_s) | (~trisb_q & portb_out_q);

  // Timer event, prescaler tick and next-state logic for all registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tmr0_d      = tmr0_q;
    presc_d     = presc_q;
    inhibit_d   = inhibit_q;
    opt_d       = opt_q;
    trisb_d     = trisb_q;
    portb_out_d = portb_out_q;
    t0_ovf_d    = 1'b0;
    exp_din_d   = 8'h00;

    // T0CS selects the internal clk or an edge of the synchronised pin; T0SE picks the edge.
    if (opt_q[5]) t0_event = opt_q[4] ? (~t0cki_s & t0cki_prev_q) : (t0cki_s & ~t0cki_prev_q);
    else          t0_event = 1'b1;

    // Prescaler output fires when the selected bit falls, giving 1:2^(PS+1).
    presc_inc      = presc_q + 8'd1;
    presc_tick     = presc_q[opt_q[2:0]] & ~presc_inc[opt_q[2:0]];
    inhibit_active = (inhibit_q != 2'd0);
    tick           = (opt_q[3] ? t0_event : (t0_event & presc_tick)) & ~inhibit_active;

    if (wr_tmr0) begin
      tmr0_d    = exp_dout_i;
      presc_d   = 8'h00;
      inhibit_d = INHIBIT_CLKS;
    end else begin
      if (inhibit_active) begin
        inhibit_d = inhibit_q - 2'd1;
        presc_d   = 8'h00;
      end else if (!opt_q[3] && t0_event) begin
        presc_d = presc_inc;
      end
      if (tick) begin
        tmr0_d   = tmr0_q + 8'd1;
        t0_ovf_d = (tmr0_q == 8'hFF);
      end
    end

    // Changing the prescaler setup restarts it from zero.
    if (opt_wr_i) begin
      opt_d   = cfg_din_i[5:0];
      presc_d = 8'h00;
    end
    if (tris_wr_i) trisb_d     = cfg_din_i;
    if (wr_portb)  portb_out_d = exp_dout_i;

    // Read mux samples pre-update state; a same-cycle write to the read address bypasses.
    if (rd_sel == TMR0_ADDR)       exp_din_d = tmr0_q;
    else if (rd_sel == PORTB_ADDR) exp_din_d = portb_rd;
    if (exp_wr_en_i && (exp_wr_addr_i[4:0] == rd_sel) &&
        (rd_sel == TMR0_ADDR || rd_sel == PORTB_ADDR)) begin
      exp_din_d = exp_dout_i;
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      t0cki_sync_q <= '0;
      portb_sync_q <= '0;
      t0cki_prev_q <= 1'b0;
      tmr0_q       <= 8'h00;
      presc_q      <= 8'h00;
      inhibit_q    <= 2'd0;
      opt_q        <= 6'h3F;
      trisb_q      <= 8'hFF;
      portb_out_q  <= 8'h00;
      exp_din_q    <= 8'h00;
      t0_ovf_q     <= 1'b0;
    end else begin
      t0cki_sync_q <= {t0cki_sync_q[SYNC_STAGES-2:0], t0cki_i};
      portb_sync_q <= {portb_sync_q[SYNC_STAGES-2:0], portb_in_i};
      t0cki_prev_q <= t0cki_s;
      tmr0_q       <= tmr0_d;
      presc_q      <= presc_d;
      inhibit_q    <= inhibit_d;
      opt_q        <= opt_d;
      trisb_q      <= trisb_d;
      portb_out_q  <= portb_out_d;
      exp_din_q    <= exp_din_d;
      t0_ovf_q     <= t0_ovf_d;
    end
  end

  assign exp_din_o   = exp_din_q;
  assign portb_out_o = portb_out_q;
  assign portb_oe_o  = ~trisb_q;
  assign t0_ovf_o    = t0_ovf_q;

endmodule

// File: tb/tb_exp_tmr0_portb.sv
// Directed testbench for exp_tmr0_portb: reset, internal counting, prescaler,
// overflow pulse with write inhibit, external clock edges, PORTB and reset mid-count.
module tb_exp_tmr0_portb;

  logic       clk = 1'b0;
  logic       rst;
  logic       exp_wr_en;
  logic [6:0] exp_wr_addr;
  logic [7:0] exp_dout;
  logic [6:0] exp_rd_addr;
  logic [7:0] exp_din;
  logic       opt_wr;
  logic       tris_wr;
  logic [7:0] cfg_din;
  logic       t0cki;
  logic [7:0] portb_in;
  logic [7:0] portb_out;
  logic [7:0] portb_oe;
  logic       t0_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  exp_tmr0_portb dut (
    .clk           (clk),
    .rst           (rst),
    .exp_wr_en_i   (exp_wr_en),
    .exp_wr_addr_i (exp_wr_addr),
    .exp_dout_i    (exp_dout),
    .exp_rd_addr_i (exp_rd_addr),
    .exp_din_o     (exp_din),
    .opt_wr_i      (opt_wr),
    .tris_wr_i     (tris_wr),
    .cfg_din_i     (cfg_din),
    .t0cki_i       (t0cki),
    .portb_in_i    (portb_in),
    .portb_out_o   (portb_out),
    .portb_oe_o    (portb_oe),
    .t0_ovf_o      (t0_ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    exp_wr_en = 1'b0;
    opt_wr    = 1'b0;
    tris_wr   = 1'b0;
  endtask

  // Same-cycle OPTION load plus TMR0 write.
  task automatic setup_timer(input logic [7:0] opt_val, input logic [7:0] tmr_val);
    opt_wr      = 1'b1;
    cfg_din     = opt_val;
    exp_wr_en   = 1'b1;
    exp_wr_addr = 7'h01;
    exp_dout    = tmr_val;
    exp_rd_addr = 7'h01;
    step();
    idle_strobes();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_strobes();
    exp_wr_addr = '0; exp_dout = '0; exp_rd_addr = 7'h01;
    cfg_din = '0; t0cki = 1'b0; portb_in = 8'h00;
    step(); step();
    n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL reset_exp_din: got %h want 00", exp_din); end
    n_tests++; if (portb_oe !== 8'h00) begin n_fail++; $display("FAIL reset_portb_oe: got %h want 00", portb_oe); end
    n_tests++; if (portb_out !== 8'h00) begin n_fail++; $display("FAIL reset_portb_out: got %h want 00", portb_out); end
    n_tests++; if (t0_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_t0_ovf: got %b want 0", t0_ovf); end
    rst = 1'b0;
    step(); step();
    n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL reset_tmr0_read: got %h want 00", exp_din); end
  endtask

  // Internal clock, no prescaler: value held two clks after the write, then +1 per clk.
  task automatic test_internal();
    logic [7:0] exp;
    setup_timer(8'h08, 8'h10);
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k <= 3) ? 8'h10 : 8'(8'h10 + k - 3);
      n_tests++; if (exp_din !== exp) begin n_fail++; $display("FAIL internal_k%0d: got %h want %h", k, exp_din, exp); end
    end
  endtask

  // Prescaler 1:4: sixteen counted clks advance TMR0 by four.
  task automatic test_prescaler();
    logic [7:0] exp;
    int j;
    setup_timer(8'h01, 8'h40);
    for (int k = 1; k <= 19; k++) begin
      step();
      j = k - 1;
      exp = (j < 2) ? 8'h40 : 8'(8'h40 + (j - 2) / 4);
      n_tests++; if (exp_din !== exp) begin n_fail++; $display("FAIL presc_k%0d: got %h want %h", k, exp_din, exp); end
    end
  endtask

  // Write FE: holds two clks, then FF, then 00 with a single ovf pulse.
  task automatic test_overflow();
    logic exp_ovf;
    setup_timer(8'h08, 8'hFE);
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_ovf = (k == 4);
      n_tests++; if (t0_ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_k%0d: got %b want %b", k, t0_ovf, exp_ovf); end
      if (k == 3) begin
        n_tests++; if (exp_din !== 8'hFE) begin n_fail++; $display("FAIL ovf_hold: got %h want FE", exp_din); end
      end
      if (k == 4) begin
        n_tests++; if (exp_din !== 8'hFF) begin n_fail++; $display("FAIL ovf_ff: got %h want FF", exp_din); end
      end
      if (k == 5) begin
        n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL ovf_wrap: got %h want 00", exp_din); end
      end
    end
  endtask

  task automatic pulse_t0cki(input int n);
    for (int i = 0; i < n; i++) begin
      t0cki = 1'b1; repeat (4) step();
      t0cki = 1'b0; repeat (4) step();
    end
  endtask

  // External clock on rising edges, then falling edges only.
  task automatic test_external();
    setup_timer(8'h28, 8'h00);
    repeat (4) step();
    pulse_t0cki(5);
    repeat (4) step();
    n_tests++; if (exp_din !== 8'h05) begin n_fail++; $display("FAIL ext_rising: got %h want 05", exp_din); end

    setup_timer(8'h38, 8'h00);
    repeat (3) step();
    t0cki = 1'b1; repeat (6) step();
    n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL ext_fall_ignores_rise: got %h want 00", exp_din); end
    t0cki = 1'b0; repeat (6) step();
    n_tests++; if (exp_din !== 8'h01) begin n_fail++; $display("FAIL ext_fall_one: got %h want 01", exp_din); end
    pulse_t0cki(4);
    repeat (4) step();
    n_tests++; if (exp_din !== 8'h05) begin n_fail++; $display("FAIL ext_falling: got %h want 05", exp_din); end
  endtask

  task automatic test_portb();
    // OPTION and TRIS strobes together with a PORTB write and read.
    opt_wr = 1'b1; tris_wr = 1'b1; cfg_din = 8'h0F;
    exp_wr_en = 1'b1; exp_wr_addr = 7'h06; exp_dout = 8'hA5;
    exp_rd_addr = 7'h06; portb_in = 8'h3C;
    step();
    idle_strobes();
    n_tests++; if (exp_din !== 8'hA5) begin n_fail++; $display("FAIL portb_bypass_a5: got %h want A5", exp_din); end
    n_tests++; if (portb_oe !== 8'hF0) begin n_fail++; $display("FAIL portb_oe: got %h want F0", portb_oe); end
    step(); step();
    n_tests++; if (exp_din !== 8'hAC) begin n_fail++; $display("FAIL portb_read_ac: got %h want AC", exp_din); end

    // Bank-mirrored write and read in the same cycle.
    exp_wr_en = 1'b1; exp_wr_addr = 7'h46; exp_dout = 8'h11; exp_rd_addr = 7'h26;
    step();
    exp_wr_en = 1'b0;
    n_tests++; if (exp_din !== 8'h11) begin n_fail++; $display("FAIL portb_bypass_11: got %h want 11", exp_din); end
    step();
    n_tests++; if (exp_din !== 8'h1C) begin n_fail++; $display("FAIL portb_read_1c: got %h want 1C", exp_din); end
    n_tests++; if (portb_out !== 8'h11) begin n_fail++; $display("FAIL portb_out: got %h want 11", portb_out); end

    // Unmapped address: reads zero, write has no effect.
    exp_wr_en = 1'b1; exp_wr_addr = 7'h02; exp_dout = 8'hFF; exp_rd_addr = 7'h02;
    step();
    exp_wr_en = 1'b0;
    n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h want 00", exp_din); end
    n_tests++; if (portb_out !== 8'h11) begin n_fail++; $display("FAIL unmapped_write: got %h want 11", portb_out); end

    // New pin values propagate through the synchroniser.
    portb_in = 8'hC3; exp_rd_addr = 7'h06;
    repeat (3) step();
    n_tests++; if (exp_din !== 8'h13) begin n_fail++; $display("FAIL portb_read_13: got %h want 13", exp_din); end
  endtask

  // Reset on the edge where FF would wrap: everything clears, no ovf pulse.
  task automatic test_reset_mid();
    setup_timer(8'h08, 8'hFE);
    repeat (3) step();
    rst = 1'b1;
    step();
    n_tests++; if (t0_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", t0_ovf); end
    n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL midrst_exp_din: got %h want 00", exp_din); end
    n_tests++; if (portb_oe !== 8'h00) begin n_fail++; $display("FAIL midrst_portb_oe: got %h want 00", portb_oe); end
    n_tests++; if (portb_out !== 8'h00) begin n_fail++; $display("FAIL midrst_portb_out: got %h want 00", portb_out); end
    rst = 1'b0;
    step();
    n_tests++; if (t0_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf_after: got %b want 0", t0_ovf); end
    n_tests++; if (exp_din !== 8'h00) begin n_fail++; $display("FAIL midrst_tmr0: got %h want 00", exp_din); end
  endtask

  initial begin
    test_reset();
    test_internal();
    test_prescaler();
    test_overflow();
    test_external();
    test_portb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
